// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the dual-requester SPI arbiter.
package spi_arb_pkg;

  // Transfer phases, as seen from outside the block (dbg_state).
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4,
    GAP   = 3'd5
  } state_e;

  // Arbiter-level phases; the byte engine owns SETUP/SHIFT/HOLD/DONE
  // while the arbiter sits in ARB_XFER.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_XFER = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CLK_DIV = 4;

  // Round-robin choice: a lone request wins, a tie goes to the port
  // that was not granted last time.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return ~last;
    else if (r1)  return PORT1;
    else          return PORT0;
  endfunction

endpackage

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte engine: setup delay, DATA_W-bit MSB-first shift with
// sclk generation, a hold phase, then a one-cycle done.
module spi_byte_engine
  import spi_arb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] tx_i,
  input  logic              miso_i,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic [DATA_W-1:0] rx_o,
  output logic              done_o,
  output logic              active_o,
  output state_e            state_o
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * DATA_W);
  localparam logic [CNT_W-1:0] HP_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * DATA_W - 1);
  // Half-period index that ends with the final falling edge; mosi must
  // keep the last bit there instead of shifting in a zero.
  localparam logic [BIT_W-1:0] FALL_LAST = BIT_W'(2 * DATA_W - 2);

  state_e            state_q,   state_d;
  logic [CNT_W-1:0]  hp_cnt_q,  hp_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              sclk_q,    sclk_d;
  logic [DATA_W-1:0] tx_sr_q,   tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q,   rx_sr_d;
  logic              hp_last;

  assign hp_last = (hp_cnt_q == HP_LAST);

  // Next-state, half-period timing, edge generation and shifting.
  always_comb begin
    state_d   = state_q;
    hp_cnt_d  = hp_cnt_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = SETUP;
          tx_sr_d   = tx_i;
          hp_cnt_d  = '0;
          bit_cnt_d = '0;
        end
      end
      SETUP: begin
        if (hp_last) begin
          // First rising edge: slave data is sampled on the way up.
          state_d  = SHIFT;
          hp_cnt_d = '0;
          sclk_d   = 1'b1;
          rx_sr_d  = {rx_sr_q[DATA_W-2:0], miso_i};
        end else begin
          hp_cnt_d = hp_cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (hp_last) begin
          hp_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = HOLD;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            sclk_d    = ~sclk_q;
            if (sclk_q) begin
              if (bit_cnt_q != FALL_LAST) tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
            end else begin
              rx_sr_d = {rx_sr_q[DATA_W-2:0], miso_i};
            end
          end
        end else begin
          hp_cnt_d = hp_cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (hp_last) begin
          state_d  = DONE;
          hp_cnt_d = '0;
        end else begin
          hp_cnt_d = hp_cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Engine state register; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hp_cnt_q  <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
    end else begin
      state_q   <= state_d;
      hp_cnt_q  <= hp_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
    end
  end

  assign sclk_o   = sclk_q;
  assign mosi_o   = tx_sr_q[DATA_W-1];
  assign rx_o     = rx_sr_q;
  assign done_o   = (state_q == DONE);
  assign active_o = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
  assign state_o  = state_q;

endmodule

// File: rtl/spi_dual_req_arbiter.sv
// Two requesters sharing one SPI byte engine, round-robin arbitrated.
// Handshake: reqN is a level the requester holds until it sees the
// one-cycle gntN; gntN is also the moment txN has been captured, so
// after gntN the requester may drop reqN or change txN freely. doneN
// pulses once when rxN carries the new byte; rxN then holds until the
// next doneN. Keeping reqN high past doneN asks for another transfer.
module spi_dual_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [DATA_W-1:0] tx0,
  output logic              gnt0,
  output logic              done0,
  output logic [DATA_W-1:0] rx0,
  input  logic              req1,
  input  logic [DATA_W-1:0] tx1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rx1,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs0_n,
  output logic              cs1_n,
  output state_e            dbg_state
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CLK_DIV - 1);

  arb_state_e        arb_q,     arb_d;
  logic              port_q,    port_d;
  logic              last_q,    last_d;
  logic              gnt0_q,    gnt0_d;
  logic              gnt1_q,    gnt1_d;
  logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0] rx0_q,     rx0_d;
  logic [DATA_W-1:0] rx1_q,     rx1_d;

  logic              pick;
  logic              start;
  logic [DATA_W-1:0] tx_sel;
  logic              eng_done;
  logic              eng_active;
  logic [DATA_W-1:0] eng_rx;
  state_e            eng_state;

  assign pick   = rr_pick(req0, req1, last_q);
  assign tx_sel = (pick == PORT1) ? tx1 : tx0;

  // Arbiter: sample requests only when idle, then wait out transfer and gap.
  always_comb begin
    arb_d     = arb_q;
    port_d    = port_q;
    last_d    = last_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    gap_cnt_d = gap_cnt_q;
    start     = 1'b0;
    case (arb_q)
      ARB_IDLE: begin
        if (req0 || req1) begin
          arb_d  = ARB_XFER;
          port_d = pick;
          last_d = pick;
          gnt0_d = (pick == PORT0);
          gnt1_d = (pick == PORT1);
          start  = 1'b1;
        end
      end
      ARB_XFER: begin
        if (eng_done) begin
          arb_d     = ARB_GAP;
          gap_cnt_d = '0;
        end
      end
      ARB_GAP: begin
        if (gap_cnt_q == GAP_LAST) arb_d = ARB_IDLE;
        else                       gap_cnt_d = gap_cnt_q + CNT_W'(1);
      end
      default: arb_d = ARB_IDLE;
    endcase
  end

  // Received-byte steering: only the granted port's holding register moves.
  always_comb begin
    rx0_d = rx0_q;
    rx1_d = rx1_q;
    if (done0) rx0_d = eng_rx;
    if (done1) rx1_d = eng_rx;
  end

  // Arbiter registers; last starts at port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_q     <= ARB_IDLE;
      port_q    <= PORT0;
      last_q    <= PORT1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      gap_cnt_q <= '0;
      rx0_q     <= '0;
      rx1_q     <= '0;
    end else begin
      arb_q     <= arb_d;
      port_q    <= port_d;
      last_q    <= last_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      gap_cnt_q <= gap_cnt_d;
      rx0_q     <= rx0_d;
      rx1_q     <= rx1_d;
    end
  end

  spi_byte_engine #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .tx_i     (tx_sel),
    .miso_i   (miso),
    .sclk_o   (sclk),
    .mosi_o   (mosi),
    .rx_o     (eng_rx),
    .done_o   (eng_done),
    .active_o (eng_active),
    .state_o  (eng_state)
  );

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = eng_done && (port_q == PORT0);
  assign done1 = eng_done && (port_q == PORT1);
  // During the done cycle the fresh byte bypasses the holding register.
  assign rx0   = done0 ? eng_rx : rx0_q;
  assign rx1   = done1 ? eng_rx : rx1_q;
  // port_q is a single bit, so at most one select can ever be low.
  assign cs0_n = ~(eng_active && (port_q == PORT0));
  assign cs1_n = ~(eng_active && (port_q == PORT1));
  assign busy  = (arb_q != ARB_IDLE);

  assign dbg_state = (arb_q == ARB_IDLE) ? IDLE :
                     (arb_q == ARB_GAP)  ? GAP  : eng_state;

endmodule

// File: tb/tb_spi_dual_req_arbiter.sv
// Bench for spi_dual_req_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transfer-timeline reference model.
module tb_spi_dual_req_arbiter;

  localparam int DW         = 8;
  localparam int CD         = 4;
  localparam int T_DONE     = (2 * DW + 2) * CD;  // gnt -> done
  localparam int T_BUSY_END = T_DONE + CD;        // last busy cycle after gnt
  localparam int T_IDLE     = T_BUSY_END + 1;     // first idle cycle after gnt

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          req0, req1, miso;
  logic [DW-1:0] tx0, tx1;
  logic          gnt0, gnt1, done0, done1, busy, sclk, mosi, cs0_n, cs1_n;
  logic [DW-1:0] rx0, rx1;
  spi_arb_pkg::state_e dbg_state;

  spi_dual_req_arbiter #(.DATA_W(DW), .CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .tx0(tx0), .gnt0(gnt0), .done0(done0), .rx0(rx0),
    .req1(req1), .tx1(tx1), .gnt1(gnt1), .done1(done1), .rx1(rx1),
    .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso),
    .cs0_n(cs0_n), .cs1_n(cs1_n), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // One transfer is in flight at a time, so the model is a single record
  // plus the time the arbiter is next free to sample requests.
  bit            m_valid;
  int            m_t;           // cycle of the gnt pulse
  bit            m_port;
  logic [DW-1:0] m_tx, m_slave;
  bit            m_last;
  int            m_idle_from;
  logic [DW-1:0] m_rx0, m_rx1;
  logic [DW-1:0] slave0, slave1; // byte each slave returns next time
  logic [DW-1:0] cap;            // mosi captured at observed sclk rises
  logic          prev_sclk;
  bit            keep_on_gnt;
  logic [DW-1:0] exp_q[$];       // expected rx bytes in completion order

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid     = 1'b0;
    m_last      = 1'b1;
    m_rx0       = '0;
    m_rx1       = '0;
    m_idle_from = 0;
    exp_q.delete();
  endtask

  // Compare every output of the current cycle against the timeline model.
  task automatic check_cycle();
    int  rel;
    bit  e_gnt, e_cs, e_done, e_busy, e_sclk;
    logic [DW-1:0] e_rx;
    rel    = cyc - m_t;
    e_gnt  = m_valid && (rel == 0);
    e_cs   = m_valid && (rel >= 0) && (rel < T_DONE);
    e_done = m_valid && (rel == T_DONE);
    e_busy = m_valid && (rel >= 0) && (rel <= T_BUSY_END);
    e_sclk = m_valid && (rel >= CD) && (rel < (2 * DW + 1) * CD) && ((((rel - CD) / CD) % 2) == 0);
    if (prev_sclk === 1'b0 && sclk === 1'b1) cap = {cap[DW-2:0], mosi};
    if (e_done) begin
      e_rx = exp_q.pop_front();
      if (m_port) m_rx1 = e_rx; else m_rx0 = e_rx;
      chk("mosi_byte", 32'(cap), 32'(m_tx));
    end
    chk("gnt0",  32'(gnt0),  32'(e_gnt && !m_port));
    chk("gnt1",  32'(gnt1),  32'(e_gnt && m_port));
    chk("done0", 32'(done0), 32'(e_done && !m_port));
    chk("done1", 32'(done1), 32'(e_done && m_port));
    chk("cs0_n", 32'(cs0_n), 32'(!(e_cs && !m_port)));
    chk("cs1_n", 32'(cs1_n), 32'(!(e_cs && m_port)));
    chk("cs_excl", 32'(cs0_n | cs1_n), 32'd1);
    chk("busy",  32'(busy),  32'(e_busy));
    chk("sclk",  32'(sclk),  32'(e_sclk));
    chk("rx0",   32'(rx0),   32'(m_rx0));
    chk("rx1",   32'(rx1),   32'(m_rx1));
  endtask

  // ---------------- driver tasks ----------------
  // One clock: model decides on this cycle's inputs, slave drives miso,
  // then outputs of the next cycle are checked away from the edge.
  task automatic step();
    int jn;
    if (rst_n && cyc >= m_idle_from && (req0 || req1)) begin
      if (req0 && req1) m_port = !m_last;
      else              m_port = req1;
      m_last      = m_port;
      m_valid     = 1'b1;
      m_t         = cyc + 1;
      m_tx        = m_port ? tx1 : tx0;
      m_slave     = m_port ? slave1 : slave0;
      m_idle_from = m_t + T_IDLE;
      cap         = '0;
      exp_q.push_back(m_slave);
    end
    miso = 1'($urandom_range(0, 1));
    if (m_valid && (cyc + 1 <= m_t + (2 * DW + 1) * CD) && (cyc + 1 >= m_t)) begin
      jn = (cyc < m_t + CD) ? 0 : (cyc - m_t - CD) / (2 * CD) + 1;
      if (jn < DW) miso = m_slave[DW-1-jn];
    end
    prev_sclk = sclk;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_cycle();
    if (gnt0 && !keep_on_gnt) req0 = 1'b0;
    if (gnt1 && !keep_on_gnt) req1 = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_gnt(input bit p);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      seen = p ? gnt1 : gnt0;
    end
    chk("wait_gnt", 32'(seen), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    run(2);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; tx0 = '0; tx1 = '0; miso = 1'b0;
    slave0 = '0; slave1 = '0; keep_on_gnt = 1'b0; cap = '0; prev_sclk = 1'b0;
    m_port = 1'b0; m_t = 0; m_tx = '0; m_slave = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sclk",  32'(sclk),  32'd0);
    chk("rst_mosi",  32'(mosi),  32'd0);
    chk("rst_cs0_n", 32'(cs0_n), 32'd1);
    chk("rst_cs1_n", 32'(cs1_n), 32'd1);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_gnt",   32'({gnt0, gnt1, done0, done1}), 32'd0);
    chk("rst_rx",    32'({rx0, rx1}), 32'd0);
    rst_n = 1'b1;

    // Single transfer: tx 0xA5, slave answers 0x3C.
    slave0 = 8'h3C; tx0 = 8'hA5; req0 = 1'b1;
    run(100);
    chk("single_rx0", 32'(rx0), 32'h3C);
    chk("single_rx1", 32'(rx1), 32'h00);

    // Tie straight after reset: port 0 first, then port 1.
    do_reset();
    tx0 = 8'h11; tx1 = 8'hC7; slave0 = 8'h5A; slave1 = 8'h96;
    req0 = 1'b1; req1 = 1'b1;
    run(180);
    chk("tie_rx0", 32'(rx0), 32'h5A);
    chk("tie_rx1", 32'(rx1), 32'h96);

    // Fairness: both held high across four transfers.
    keep_on_gnt = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4 * T_IDLE; i++) begin
      tx0 = 8'($urandom); tx1 = 8'($urandom);
      slave0 = 8'($urandom); slave1 = 8'($urandom);
      step();
    end
    req0 = 1'b0; req1 = 1'b0; keep_on_gnt = 1'b0;
    run(100);

    // Late request: req1 rises while port 0 is shifting.
    tx0 = 8'h3E; slave0 = 8'hC1; req0 = 1'b1;
    wait_gnt(1'b0);
    run(20);
    tx1 = 8'h81; slave1 = 8'h7E; req1 = 1'b1;
    run(170);

    // Reset in the middle of a shift.
    tx0 = 8'h55; slave0 = 8'hF0; req0 = 1'b1;
    wait_gnt(1'b0);
    run(30);
    rst_n = 1'b0;
    #1;
    chk("midrst_cs0_n", 32'(cs0_n), 32'd1);
    chk("midrst_sclk",  32'(sclk),  32'd0);
    chk("midrst_busy",  32'(busy),  32'd0);
    model_reset();
    run(3);
    rst_n = 1'b1;
    tx0 = 8'h6B; slave0 = 8'hE1; req0 = 1'b1;
    run(100);
    chk("midrst_rx0", 32'(rx0), 32'hE1);

    // tx changes after the gnt cycle must not reach mosi.
    tx0 = 8'hFF; slave0 = 8'h24; req0 = 1'b1;
    wait_gnt(1'b0);
    step();
    tx0 = 8'h00;
    run(90);

    // Random traffic with withdrawals, back-to-back requests and resets.
    for (int i = 0; i < 3000; i++) begin
      keep_on_gnt = ($urandom_range(0, 3) == 0);
      if (!req0) begin
        if ($urandom_range(0, 15) == 0) begin req0 = 1'b1; tx0 = 8'($urandom); end
      end else if ($urandom_range(0, 79) == 0) req0 = 1'b0;
      if (!req1) begin
        if ($urandom_range(0, 15) == 0) begin req1 = 1'b1; tx1 = 8'($urandom); end
      end else if ($urandom_range(0, 79) == 0) req1 = 1'b0;
      if ($urandom_range(0, 7) == 0) tx0 = 8'($urandom);
      if ($urandom_range(0, 7) == 0) tx1 = 8'($urandom);
      if ($urandom_range(0, 9) == 0) slave0 = 8'($urandom);
      if ($urandom_range(0, 9) == 0) slave1 = 8'($urandom);
      if ($urandom_range(0, 999) == 0) do_reset();
      else step();
    end
    req0 = 1'b0; req1 = 1'b0; keep_on_gnt = 1'b0;
    run(100);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
